pipe_mem_arbiter: RTL



---
 rtl/pipe_mem_pkg.sv | 26 ++
 rtl/pipe_mem_wait_cnt.sv | 38 +++
 rtl/pipe_mem_arbiter.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/pipe_mem_pkg.sv
//==============================================================================
// Module   : pipe_mem_pkg
// Brief    : Shared FSM, owner and error-data definitions for pipe_mem_arbiter.
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

package pipe_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_t;

  localparam logic [31:0] ERR_RDATA = 32'h0;

endpackage

`default_nettype wire

// File: rtl/pipe_mem_wait_cnt.sv
//==============================================================================
// Module   : pipe_mem_wait_cnt
// Brief    : BUSY-state wait counter with terminal count at MAX_WAIT-1.
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module pipe_mem_wait_cnt #(
  parameter int MAX_WAIT = 16
) (
  input  logic Clock,
  input  logic Resetn,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_terminal
);

  localparam int               CNT_W  = 8;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(MAX_WAIT - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_terminal = (r_cnt == C_LAST);

endmodule

`default_nettype wire

// File: rtl/pipe_mem_arbiter.sv
//==============================================================================
// Module   : pipe_mem_arbiter
// Brief    : Serialises IF and MEM stage accesses onto one variable-latency
//            memory port. Define ARB_RR_EN for round-robin arbitration;
//            otherwise DM has fixed priority over IF.
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module pipe_mem_arbiter
  import pipe_mem_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 16
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  output logic              if_stall,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_valid,
  output logic              dm_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              bus_err
);

  state_t            r_state;
  state_t            w_state_nxt;
  owner_t            r_owner;
  logic              r_abort;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_dm_rdata;
  logic              w_any_req;
  logic              w_pick_dm;
  logic              w_grant;
  logic              w_wait_clr;
  logic              w_wait_en;
  logic              w_wait_tc;

  assign w_any_req = if_req | dm_req;
  assign w_grant   = (r_state == IDLE) && w_any_req;

`ifdef ARB_RR_EN
  owner_t r_last_grant;

  // On a tie, the requester that did not win last time goes first.
  assign w_pick_dm = dm_req && (!if_req || (r_last_grant == OWN_IF));

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_last_grant <= OWN_IF;
    end else if (w_grant) begin
      r_last_grant <= w_pick_dm ? OWN_DM : OWN_IF;
    end
  end
`else
  // The load/store belongs to the older instruction, so it wins ties.
  assign w_pick_dm = dm_req;
`endif

  assign w_wait_clr = (r_state == IDLE);
  assign w_wait_en  = (r_state == BUSY) && !mem_ready;

  pipe_mem_wait_cnt #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_cnt (
    .Clock      (Clock),
    .Resetn     (Resetn),
    .i_clear    (w_wait_clr),
    .i_enable   (w_wait_en),
    .o_terminal (w_wait_tc)
  );

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_any_req) w_state_nxt = BUSY;
      BUSY:    if (mem_ready || w_wait_tc) w_state_nxt = RESP;
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    if_valid = 1'b0;
    dm_valid = 1'b0;
    bus_err  = 1'b0;
    if (r_state == RESP) begin
      if_valid = (r_owner == OWN_IF);
      dm_valid = (r_owner == OWN_DM);
      bus_err  = r_abort;
    end
  end

  // Memory-side request registers and per-owner read data capture.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_owner     <= OWN_IF;
      r_abort     <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_rdata  <= '0;
      r_dm_rdata  <= '0;
    end else if (w_grant) begin
      r_owner     <= w_pick_dm ? OWN_DM : OWN_IF;
      r_abort     <= 1'b0;
      r_mem_req   <= 1'b1;
      r_mem_we    <= w_pick_dm & dm_we;
      r_mem_addr  <= w_pick_dm ? dm_addr : if_addr;
      r_mem_wdata <= w_pick_dm ? dm_wdata : '0;
    end else if ((r_state == BUSY) && mem_ready) begin
      r_mem_req <= 1'b0;
      if (r_owner == OWN_IF) begin
        r_if_rdata <= mem_rdata;
      end else if (!r_mem_we) begin
        r_dm_rdata <= mem_rdata;
      end
    end else if ((r_state == BUSY) && w_wait_tc) begin
      r_mem_req <= 1'b0;
      r_abort   <= 1'b1;
      if (r_owner == OWN_IF) begin
        r_if_rdata <= DATA_W'(ERR_RDATA);
      end else begin
        r_dm_rdata <= DATA_W'(ERR_RDATA);
      end
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign if_rdata  = r_if_rdata;
  assign dm_rdata  = r_dm_rdata;
  assign if_stall  = if_req & ~if_valid;
  assign dm_stall  = dm_req & ~dm_valid;

endmodule

`default_nettype wire
